panel_shift_driver: RTL



---
 rtl/panel_pkg.sv | 14 +
 rtl/piso_shift.sv | 45 ++++
 rtl/panel_shift_driver.sv | 100 ++++++++++
 3 files changed

// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared state type and default sizes for the panel shift driver
package panel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        ADVANCE = 2'd3
    } drv_state_t;

    localparam int PANEL_N    = 8;
    localparam int PANEL_ROWS = 8;

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-load serial-out shift register (LSB_FIRST_EN selects bit order)
module piso_shift #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] din_i,
    output logic         ser_o
);

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;

    // Next register value: a load wins over a shift; the vacated bit fills with 0
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = din_i;
        end else if (shift_i) begin
`ifdef LSB_FIRST_EN
            shreg_d = {1'b0, shreg_q[N-1:1]};
`else
            shreg_d = {shreg_q[N-2:0], 1'b0};
`endif
        end
    end

    // Shift register storage with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

`ifdef LSB_FIRST_EN
    assign ser_o = shreg_q[0];
`else
    assign ser_o = shreg_q[N-1];
`endif

endmodule

// File: rtl/panel_shift_driver.sv
// rtl/panel_shift_driver.sv - row serialiser with latch/row-increment strobes and frame tracking (LSB_FIRST_EN: LSB-first bit order)
module panel_shift_driver
    import panel_pkg::*;
#(
    parameter int N    = PANEL_N,
    parameter int ROWS = PANEL_ROWS,
    localparam int RW  = $clog2(ROWS)
) (
    input  logic          STCP,
    input  logic          rst,
    input  logic [N-1:0]  din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          ser,
    output logic          shift_en,
    output logic          latch,
    output logic          row_inc,
    output logic [RW-1:0] row,
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = $clog2(N);

    drv_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_d;
    logic          accept;
    logic          row_last;
    logic          piso_ser;

    assign din_ready = ((state_q == IDLE) || (state_q == ADVANCE)) && !rst;
    assign accept    = din_valid && din_ready;
    assign row_last  = (row_q == RW'(ROWS - 1));

    // Explicit wrap so non-power-of-two ROWS never counts into unused codes
    always_comb begin
        row_d = row_q;
        if (state_q == ADVANCE) begin
            row_d = row_last ? '0 : row_q + RW'(1);
        end
    end

    piso_shift #(.N(N)) u_piso (
        .clk_i   (STCP),
        .rst_i   (rst),
        .load_i  (accept),
        .shift_i (state_q == SHIFT),
        .din_i   (din),
        .ser_o   (piso_ser)
    );

    // Word sequencing FSM with bit counter and row scan position
    always_ff @(posedge STCP) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            row_q <= row_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    state_q <= ADVANCE;
                end
                ADVANCE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode only from registered state, so latch and row_inc are mutually exclusive
    assign shift_en   = (state_q == SHIFT);
    assign ser        = shift_en && piso_ser;
    assign latch      = (state_q == LATCH);
    assign row_inc    = (state_q == ADVANCE);
    assign frame_done = (state_q == ADVANCE) && row_last;
    assign busy       = (state_q != IDLE);
    assign row        = row_q;

endmodule
